// File: rtl/spike_frame_writer.sv
// spike_frame_writer: turns a pixel stream into spike times (brighter pixel, earlier spike),
// packs NUM_SPIKES times per word and writes each completed word to the next memory address.
module spike_frame_writer #(
    parameter int unsigned NUM_SPIKES      = 16,
    parameter int unsigned LOG_TIME_PERIOD = 3,
    parameter int unsigned PIXEL_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH      = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_l,
    input  logic                                  clear,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PIXEL_WIDTH-1:0]                in_pixel,
    output logic                                  wr_en,
    input  logic                                  wr_ready,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [NUM_SPIKES*LOG_TIME_PERIOD-1:0] wr_data,
    output logic [15:0]                           frame_count
);

    localparam int unsigned CntW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_SPIKES - 1);
    localparam int unsigned DataW = NUM_SPIKES * LOG_TIME_PERIOD;

    typedef enum logic {
        StFill,
        StWrite
    } state_e;

    state_e                     state_q;
    logic [CntW-1:0]            cnt_q;
    logic [DataW-1:0]           wr_data_q;
    logic [ADDR_WIDTH-1:0]      wr_addr_q;
    logic [15:0]                frame_count_q;
    logic                       wr_en_q;
    logic [LOG_TIME_PERIOD-1:0] spike_d;

    // Temporal encoding: invert the top bits so the brightest pixel spikes at t=0.
    always_comb begin
        spike_d = ~in_pixel[PIXEL_WIDTH-1 -: LOG_TIME_PERIOD];
    end

    // Fill/write FSM; every output except in_ready is a register of this block.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= StFill;
            cnt_q         <= '0;
            wr_data_q     <= '0;
            wr_addr_q     <= '0;
            frame_count_q <= '0;
            wr_en_q       <= 1'b0;
        end else if (clear) begin
            // Abandons any partial frame or pending write; stale fields are left alone.
            state_q       <= StFill;
            cnt_q         <= '0;
            wr_addr_q     <= '0;
            frame_count_q <= '0;
            wr_en_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_valid) begin
                        for (int k = 0; k < int'(NUM_SPIKES); k++) begin
                            if (cnt_q == CntW'(k)) begin
                                wr_data_q[k*LOG_TIME_PERIOD +: LOG_TIME_PERIOD] <= spike_d;
                            end
                        end
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            state_q <= StWrite;
                            wr_en_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (wr_ready) begin
                        // Address wraps naturally; the reader paces itself.
                        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                        if (frame_count_q != 16'hFFFF) begin
                            frame_count_q <= frame_count_q + 16'd1;
                        end
                        state_q <= StFill;
                        wr_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StFill;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready depends only on state so it never combinationally follows in_valid.
    always_comb begin
        in_ready = (state_q == StFill);
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_count = frame_count_q;

endmodule
